// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared FSM state encodings and the simulation debounce default
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_CHECK_HI  = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_CHECK_LO  = 2'd3
    } state_t;

    // Board builds override this with 500000.
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/button_debouncer_sync_ff.sv
// sync_ff: N-stage flop synchroniser for an asynchronous single-bit input
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] s;

    always_ff @(posedge clk or negedge rst)
        if (!rst) s <= '0;
        else      s <= {s[N-2:0], d};

    assign q = s[N-1];

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw button and accepts a level only after it stays stable
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter  int SYNC_STAGES     = 2,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_clean,
    output logic btn_rise,
    output logic btn_fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_sync;

    sync_ff #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_STABLE_LO;
            cnt       <= '0;
            btn_clean <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
            case (state)
                ST_STABLE_LO:
                    if (btn_sync) begin
                        state <= ST_CHECK_HI;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                ST_CHECK_HI:
                    if (!btn_sync) begin
                        state <= ST_STABLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= ST_STABLE_HI;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        btn_clean <= 1'b1;
                        btn_rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                ST_STABLE_HI:
                    if (!btn_sync) begin
                        state <= ST_CHECK_LO;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                ST_CHECK_LO:
                    if (btn_sync) begin
                        state <= ST_STABLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state     <= ST_STABLE_LO;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        btn_clean <= 1'b0;
                        btn_fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                default: begin
                    state <= ST_STABLE_LO;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
